// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - instruction/data arbiter for the shared memory data port with starvation guard
// Optional ARB_STATS_EN adds a saturating conflict_cnt output.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STRB_W       = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       conflict_cnt
`endif
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_e;

  owner_e        owner_q, owner_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          starved;

  always_comb begin
    starved   = (starve_cnt_q == LIMIT);
    i_gnt     = i_req && (!d_req || starved);
    d_gnt     = d_req && !(i_req && starved);

    mem_addr  = '0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_wdata = d_wdata;
    mem_wstrb = '0;
    if (i_gnt) begin
      mem_addr = i_addr;
      mem_ren  = 1'b1;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_ren   = !d_we;
      mem_wen   = d_we;
      mem_wstrb = d_wstrb;
    end

    // The counter only measures a run of data wins while fetch is waiting.
    starve_cnt_d = starve_cnt_q;
    if (!i_req || i_gnt) begin
      starve_cnt_d = '0;
    end else if (d_gnt && !starved) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end

    owner_d = OWN_NONE;
    if (i_gnt) begin
      owner_d = OWN_I;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= OWN_NONE;
      starve_cnt_q <= '0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign i_rvalid = (owner_q == OWN_I);
  assign d_rvalid = (owner_q == OWN_D);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

`ifdef ARB_STATS_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (i_req && d_req && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter with a transaction-level reference model
module tb_mem_port_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ren, mem_wen;
  logic [3:0]  mem_wstrb;
`ifdef ARB_STATS_EN
  logic [31:0] conflict_cnt;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STRB_W(4), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  logic [31:0] env_mem [128];
  logic [31:0] ref_mem [128];

  int total = 0;
  int bad   = 0;

  // Requester intent and expected-response state of the reference model
  bit          ip, dp, dwe;
  logic [31:0] ia, da, dwd;
  logic [3:0]  dws;
  int          run, i_wait, conflicts;
  bit          exp_irv, exp_drv;
  logic [31:0] exp_ird, exp_drd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wr_bytes(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= env_mem[mem_addr[8:2]];
    if (mem_wen) env_mem[mem_addr[8:2]] <= wr_bytes(env_mem[mem_addr[8:2]], mem_wdata, mem_wstrb);
  end

  task automatic drive();
    i_req = ip; i_addr = ia;
    d_req = dp; d_we = dwe; d_addr = da; d_wdata = dwd; d_wstrb = dws;
  endtask

  task automatic do_cycle();
    bit gi, gd;
    @(posedge clk); #1;
    drive();
    gi = ip && (!dp || run >= LIM);
    gd = dp && !gi;
    @(negedge clk);
    chk("i_gnt", 32'(i_gnt), 32'(gi));
    chk("d_gnt", 32'(d_gnt), 32'(gd));
    chk("mem_ren", 32'(mem_ren), 32'(gi || (gd && !dwe)));
    chk("mem_wen", 32'(mem_wen), 32'(gd && dwe));
    if (gi) begin
      chk("mem_addr_i", mem_addr, ia);
      chk("mem_wstrb_i", 32'(mem_wstrb), 32'd0);
      chk("i_stall_bound", 32'(i_wait <= LIM), 32'd1);
    end else if (gd) begin
      chk("mem_addr_d", mem_addr, da);
      if (dwe) begin
        chk("mem_wdata", mem_wdata, dwd);
        chk("mem_wstrb_d", 32'(mem_wstrb), 32'(dws));
      end
    end else begin
      chk("mem_wstrb_idle", 32'(mem_wstrb), 32'd0);
    end
    chk("i_rvalid", 32'(i_rvalid), 32'(exp_irv));
    if (exp_irv) chk("i_rdata", i_rdata, exp_ird);
    chk("d_rvalid", 32'(d_rvalid), 32'(exp_drv));
    if (exp_drv) chk("d_rdata", d_rdata, exp_drd);

    if (ip && dp) conflicts++;
    exp_irv = gi;
    exp_drv = gd && !dwe;
    if (gi) exp_ird = ref_mem[ia[8:2]];
    if (gd && !dwe) exp_drd = ref_mem[da[8:2]];
    if (gd && dwe) ref_mem[da[8:2]] = wr_bytes(ref_mem[da[8:2]], dwd, dws);
    if (!ip || gi) run = 0;
    else if (gd) run++;
    if (ip && !gi) i_wait++;
    else i_wait = 0;
    if (gi) ip = 0;
    if (gd) dp = 0;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [6:0] w;
    w = 7'($urandom_range(127));
    return {23'd0, w, 2'b00};
  endfunction

  task automatic new_reqs(input int pct_i, input int pct_d);
    if (!ip && $urandom_range(99) < pct_i) begin
      ip = 1; ia = rnd_addr();
    end
    if (!dp && $urandom_range(99) < pct_d) begin
      dp = 1; dwe = 1'($urandom_range(1)); da = rnd_addr();
      dwd = $urandom; dws = 4'($urandom_range(15));
    end
  endtask

  task automatic clear_model();
    ip = 0; dp = 0; dwe = 0; ia = '0; da = '0; dwd = '0; dws = '0;
    run = 0; i_wait = 0; conflicts = 0; exp_irv = 0; exp_drv = 0;
  endtask

  task automatic mid_reset();
    @(posedge clk); #1;
    chk("pre_rst_d_rvalid", 32'(d_rvalid), 32'(exp_drv));
    rst_n = 1'b0;
    clear_model();
    drive();
    #1;
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic contention(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      if (!ip) begin ip = 1; ia = rnd_addr(); end
      if (!dp) begin dp = 1; dwe = 0; da = rnd_addr(); end
      do_cycle();
      chk(tag, 32'(i_gnt), 32'((k % 5) == 4));
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      env_mem[i] = {16'hC0DE, 16'(i)};
      ref_mem[i] = {16'hC0DE, 16'(i)};
    end
    rst_n = 1'b0;
    clear_model();
    drive();
    #1;
    chk("reset_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("reset_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("reset_gnts", 32'({i_gnt, d_gnt}), 32'd0);
    chk("reset_mem_en", 32'({mem_ren, mem_wen}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < 3; k++) begin
      ip = 1; ia = 32'(k * 4);
      do_cycle();
      chk("istream_gnt", 32'(i_gnt), 32'd1);
    end
    do_cycle();

    dp = 1; dwe = 1; da = 32'h100; dwd = 32'hDEADBEEF; dws = 4'b0011;
    do_cycle();
    dp = 1; dwe = 0; da = 32'h100;
    do_cycle();
    do_cycle();
    chk("rd_0x100", d_rdata, 32'hC0DE_BEEF);

    dp = 1; dwe = 0; da = 32'h20;
    do_cycle();
    ip = 1; ia = 32'h40;
    do_cycle();
    do_cycle();
    do_cycle();

    contention(15, "pattern_pre");
    ip = 1; ia = rnd_addr();
    dp = 1; dwe = 0; da = rnd_addr();
    do_cycle();
    mid_reset();
    do_cycle();
    contention(10, "pattern_post_rst");
    dp = 0;
    for (int k = 0; k < 5; k++) begin
      ip = 1; ia = rnd_addr();
      do_cycle();
    end
`ifdef ARB_STATS_EN
    chk("conflict_cnt_10", conflict_cnt, 32'd10);
`endif

    for (int c = 0; c < 3000; c++) begin
      new_reqs(70, 70);
      do_cycle();
    end
    for (int c = 0; c < 400; c++) begin
      new_reqs(20, 90);
      do_cycle();
    end
    do_cycle();
    do_cycle();
`ifdef ARB_STATS_EN
    chk("conflict_cnt_end", conflict_cnt, 32'(conflicts));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
